// File: rtl/arinc708_pkg.sv
// Shared constants and types for the ARINC708 receive frame buffer.
// Top-level optional feature macro: ARINC708_RX_FRAME_TIMESTAMP_EN.
package arinc708_pkg;

    localparam int unsigned DATA_SIZE = 50;
    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned RAM_AW    = 6;
    localparam int unsigned RAM_DEPTH = 64;
    localparam int unsigned WCNT_W    = 6;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 7'h40;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 7'h41;
    localparam logic [ADDR_W-1:0] ADDR_FRM_CNT = 7'h42;
    localparam logic [ADDR_W-1:0] ADDR_DRP_CNT = 7'h43;
    localparam logic [ADDR_W-1:0] ADDR_TSTAMP  = 7'h44;

    localparam int unsigned STAT_AVAIL   = 0;
    localparam int unsigned STAT_BOTH    = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_LEN_LSB = 8;
    localparam int unsigned STAT_IRQ_EN  = 16;

    localparam int unsigned CTL_RELEASE = 0;
    localparam int unsigned CTL_IRQ_EN  = 1;
    localparam int unsigned CNT_CLEAR   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_COMMIT,
        ST_DROP
    } frame_state_e;

endpackage

// File: rtl/arinc708_bank_ram.sv
// One frame bank: simple dual-port 64x32 RAM, stream write, registered read.
module arinc708_bank_ram
    import arinc708_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [RAM_AW-1:0]    i_waddr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    input  logic [RAM_AW-1:0]    i_raddr,
    output logic [WORD_SIZE-1:0] o_rdata
);

    logic [WORD_SIZE-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        o_rdata <= mem_q[i_raddr];
    end

endmodule

// File: rtl/arinc708_rx_frame_buf.sv
// ARINC708 frame assembler: ping-pong banks, validation, Avalon-MM readout and IRQ.
// Optional microsecond frame timestamps under ARINC708_RX_FRAME_TIMESTAMP_EN.
module arinc708_rx_frame_buf #(
    parameter int unsigned DATA_SIZE = arinc708_pkg::DATA_SIZE,
    parameter int unsigned WORD_SIZE = arinc708_pkg::WORD_SIZE,
    parameter int unsigned CNT_W     = arinc708_pkg::CNT_W
`ifdef ARINC708_RX_FRAME_TIMESTAMP_EN
    , parameter int unsigned IN_AVS_CLK = 100000000
`endif
) (
    input  logic                 i_avs_clk,
    input  logic                 i_avs_rst,
    input  logic                 i_snk_rx_valid,
    input  logic [WORD_SIZE-1:0] i_snk_rx_data,
    output logic                 o_snk_rx_ready,
    input  logic                 i_arinc708_rx_active,
    input  logic                 i_arinc708_rx_compl_pe,
    input  logic                 i_arinc708_rx_err_pe,
    input  logic [6:0]           i_avs_address,
    input  logic                 i_avs_read,
    output logic [31:0]          o_avs_readdata,
    input  logic                 i_avs_write,
    input  logic [31:0]          i_avs_writedata,
    output logic                 o_irq
);

    import arinc708_pkg::*;

    frame_state_e       state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               len_err_q, len_err_d;
    logic               err_seen_q, err_seen_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [WCNT_W-1:0]  last_len_q, last_len_d;
    logic               last_err_q, last_err_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_q, irq_d;
    logic               rd_ram_q, rd_ram_d;
    logic               rd_sel_q, rd_sel_d;
    logic [31:0]        reg_rdata_q, reg_rdata_d;

    logic               ram_we_c;
    logic [RAM_AW-1:0]  ram_waddr_c;
    logic               frame_start_c;
    logic               release_c;
    logic               good_c;
    logic [31:0]        status_c;
    logic [31:0]        ts_rd_c;
    logic [WORD_SIZE-1:0] ram_rdata [2];
    logic               unused_wdata;

    assign unused_wdata = ^i_avs_writedata[31:3];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Frame FSM, bank bookkeeping, counters and register read mux.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        len_err_d   = len_err_q;
        err_seen_d  = err_seen_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        last_len_d  = last_len_q;
        last_err_d  = last_err_q;
        irq_en_d    = irq_en_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = RAM_AW'(wcnt_q);
        frame_start_c = 1'b0;
        good_c      = (wcnt_q == WCNT_W'(DATA_SIZE)) && !len_err_q && !err_seen_q;

        // Release is applied before a same-cycle commit; they touch different banks.
        release_c = i_avs_write && (i_avs_address == ADDR_CONTROL)
                    && i_avs_writedata[CTL_RELEASE] && full_q[rd_bank_q];
        if (release_c) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (i_avs_write && (i_avs_address == ADDR_CONTROL)) begin
            irq_en_d = i_avs_writedata[CTL_IRQ_EN];
        end

        case (state_q)
            ST_IDLE: begin
                if (i_snk_rx_valid) begin
                    if (!full_q[wr_bank_q]) begin
                        frame_start_c = 1'b1;
                        ram_we_c      = 1'b1;
                        ram_waddr_c   = '0;
                        wcnt_d        = WCNT_W'(1);
                        len_err_d     = 1'b0;
                        err_seen_d    = i_arinc708_rx_err_pe;
                        state_d       = i_arinc708_rx_compl_pe ? ST_COMMIT : ST_FILL;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = i_arinc708_rx_compl_pe ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FILL: begin
                if (i_snk_rx_valid) begin
                    if (wcnt_q < WCNT_W'(DATA_SIZE)) begin
                        ram_we_c = 1'b1;
                        wcnt_d   = wcnt_q + WCNT_W'(1);
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
                if (i_arinc708_rx_err_pe) begin
                    err_seen_d = 1'b1;
                end
                // Receiver dropping out mid-frame forces the frame bad.
                if (i_arinc708_rx_compl_pe) begin
                    state_d = ST_COMMIT;
                end else if (!i_arinc708_rx_active) begin
                    len_err_d = 1'b1;
                    state_d   = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (good_c) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    good_cnt_d        = sat_inc(good_cnt_q);
                end else begin
                    bad_cnt_d = sat_inc(bad_cnt_q);
                end
                last_len_d = wcnt_q;
                last_err_d = !good_c;
                err_seen_d = 1'b0;
                len_err_d  = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_DROP: begin
                if (i_arinc708_rx_compl_pe || !i_arinc708_rx_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_avs_write && (i_avs_address == ADDR_FRM_CNT) && i_avs_writedata[CNT_CLEAR]) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            drop_cnt_d = '0;
        end

        irq_d = full_d[rd_bank_d] && irq_en_d;

        status_c = '0;
        status_c[STAT_AVAIL] = full_q[rd_bank_q];
        status_c[STAT_BOTH]  = &full_q;
        status_c[STAT_ERR]   = last_err_q;
        status_c[STAT_LEN_LSB +: WCNT_W] = last_len_q;
        status_c[STAT_IRQ_EN] = irq_en_q;

        rd_ram_d    = i_avs_read && (32'(i_avs_address) < DATA_SIZE);
        rd_sel_d    = rd_bank_q;
        reg_rdata_d = '0;
        if (i_avs_read) begin
            case (i_avs_address)
                ADDR_STATUS:  reg_rdata_d = status_c;
                ADDR_CONTROL: reg_rdata_d = {30'b0, irq_en_q, 1'b0};
                ADDR_FRM_CNT: reg_rdata_d = 32'({bad_cnt_q, good_cnt_q});
                ADDR_DRP_CNT: reg_rdata_d = 32'(drop_cnt_q);
                ADDR_TSTAMP:  reg_rdata_d = ts_rd_c;
                default:      reg_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_avs_clk) begin
        if (i_avs_rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            len_err_q   <= 1'b0;
            err_seen_q  <= 1'b0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            last_len_q  <= '0;
            last_err_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            rd_ram_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            len_err_q   <= len_err_d;
            err_seen_q  <= err_seen_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            last_len_q  <= last_len_d;
            last_err_q  <= last_err_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            rd_ram_q    <= rd_ram_d;
            rd_sel_q    <= rd_sel_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

`ifdef ARINC708_RX_FRAME_TIMESTAMP_EN
    localparam int unsigned PRESC = (IN_AVS_CLK >= 1000000) ? IN_AVS_CLK / 1000000 : 1;

    logic [31:0]       presc_q, presc_d;
    logic [31:0]       usec_q, usec_d;
    logic [1:0][31:0]  ts_q, ts_d;

    // Free-running microsecond clock, sampled into the fill bank on frame start.
    always_comb begin
        presc_d = presc_q + 32'd1;
        usec_d  = usec_q;
        if (presc_q == 32'(PRESC - 1)) begin
            presc_d = '0;
            usec_d  = usec_q + 32'd1;
        end
        ts_d = ts_q;
        if (frame_start_c) begin
            ts_d[wr_bank_q] = usec_q;
        end
    end

    always_ff @(posedge i_avs_clk) begin
        if (i_avs_rst) begin
            presc_q <= '0;
            usec_q  <= '0;
            ts_q    <= '0;
        end else begin
            presc_q <= presc_d;
            usec_q  <= usec_d;
            ts_q    <= ts_d;
        end
    end

    assign ts_rd_c = ts_q[rd_bank_q];
`else
    assign ts_rd_c = '0;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        arinc708_bank_ram u_ram (
            .i_clk   (i_avs_clk),
            .i_we    (ram_we_c && (wr_bank_q == 1'(b))),
            .i_waddr (ram_waddr_c),
            .i_wdata (i_snk_rx_data),
            .i_raddr (i_avs_address[RAM_AW-1:0]),
            .o_rdata (ram_rdata[b])
        );
    end

    assign o_snk_rx_ready = 1'b1;
    assign o_irq          = irq_q;
    assign o_avs_readdata = rd_ram_q ? ram_rdata[rd_sel_q] : reg_rdata_q;

endmodule
